booth_prod_accum: RTL
=====================

Name: booth_prod_accum

Overview:
Downstream stage of the 4x4 sequential Booth multiplier. It consumes signed 8-bit products over a valid/ready handshake and sums groups of N_TERMS products into a dot-product result. Each completed sum is presented on a registered, back-pressurable output. Feeds the result collection logic of the lab datapath.

Parameters:
N_TERMS, 4, products summed per output beat (>=1)
ACC_W, 10, accumulator/output width, signed two's complement (>=8)

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous, active-low reset
clear  in  1  synchronous abort of current group, highest priority
in_valid  in  1  in_product valid
in_ready  out  1  block can accept a product this cycle
in_product  in  8  signed product from multiplier
out_valid  out  1  out_sum valid
out_ready  in  1  consumer accepts out_sum
out_sum  out  ACC_W  signed sum of N_TERMS products
ovf  out  1  saturation occurred in this group (SAT_ACC_EN only, else tied 0)
busy  out  1  group in progress (state != IDLE)

Behaviour:
- Reset (n_rst low, asynchronous) clears all state. acc=0, cnt=0, state=IDLE, out_valid=0, out_sum=0, ovf=0, busy=0. in_ready=1 as soon as reset deasserts.
- FSM states:
  - IDLE: cnt==0, acc==0.
  - ACC: 0<cnt<N_TERMS.
  - HOLD: result registered, waiting on out_ready.
- in_ready = (state != HOLD), combinational from state only. No same-cycle bypass from out handshake.
- Accept = in_valid & in_ready. On accept, acc <= acc + sign_extend(in_product to ACC_W) and cnt <= cnt+1. IDLE->ACC on first accept.
- Last term (accept while cnt==N_TERMS-1):
  - out_sum <= acc + sext(in_product).
  - out_valid <= 1.
  - acc <= 0, cnt <= 0, state <= HOLD.
  - Latency: out_valid rises the cycle after the last accepted term.
  - N_TERMS=1: every accept goes IDLE->HOLD directly.
- HOLD:
  - out_sum and ovf are stable. in_valid is ignored; no beats are consumed.
  - When out_valid & out_ready: out_valid <= 0, state <= IDLE, in_ready=1 the following cycle. out_sum keeps its last value.
- Arithmetic without SAT_ACC_EN: wraps modulo 2^ACC_W.
- clear (synchronous): acc=0, cnt=0, out_valid=0, ovf=0, state=IDLE, in any state.
  - An input beat presented the same cycle is discarded.
  - A pending HOLD result is dropped.
  - clear with out_ready in HOLD: clear wins. The result counts as not delivered.
- Reset mid-group or mid-HOLD: all partial state is lost, with no output beat.
- in_valid may stay high continuously. Back-to-back accepts are allowed every cycle in IDLE/ACC.

Optional Feature:
Macro SAT_ACC_EN.
- Defined:
  - Each addition saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - An internal sticky flag sets on any saturation within the group. It is copied to ovf with out_sum on the last term, then cleared for the next group.
  - ovf is valid while out_valid=1.
- Undefined: wrap-around arithmetic, ovf constant 0, no saturation logic synthesized.

Test Plan:
1. Hold n_rst=0 for 3 cycles, release -> out_valid=0, out_sum=0, busy=0, in_ready=1. Assert n_rst=0 mid-group after 2 terms -> no out_valid beat; next group sums from 0.
2. N_TERMS=4, out_ready=1, products 0x10,0x20,0x30,0x40 on consecutive cycles -> out_valid high exactly one cycle, one cycle after the 4th beat; out_sum=10'h0A0; in_ready low that cycle.
3. Signed products 0xF6,0x05,0xFF,0x02 (-10,+5,-1,+2) -> out_sum=10'h3FC (-4).
4. Back-pressure: out_ready=0 for 5 cycles after result -> out_valid and out_sum held, in_ready=0, in_valid beats with 0x11 not consumed. Raise out_ready -> out_valid drops next cycle, in_ready=1; next group excludes the 0x11 beats.
5. clear after 2 accepted terms (0x7F,0x7F), then 4 terms 0x01 -> out_sum=10'h004. clear asserted in HOLD with out_ready=1 -> out_valid=0 next cycle, state IDLE.
6. ACC_W=8, N_TERMS=4, four 0x7F beats:
   - with SAT_ACC_EN -> out_sum=8'h7F, ovf=1; the next group 1,1,1,1 -> 8'h04, ovf=0.
   - without SAT_ACC_EN -> out_sum=8'hFC, ovf=0.

Source files
------------

// File: rtl/booth_prod_accum.sv
// booth_prod_accum: sums groups of N_TERMS signed 8-bit products from the
// Booth multiplier into one signed ACC_W-bit result. The result is presented
// on a registered, back-pressurable output.
// Optional feature: define SAT_ACC_EN for saturating adds and the ovf flag.
// Without it, the adds wrap modulo 2^ACC_W and ovf is tied to 0.
// Ports:
//   clk, n_rst          clock (rising edge), async active-low reset
//   clear               synchronous abort of the current group/result
//   in_valid/in_ready   product handshake; in_product is signed 8-bit
//   out_valid/out_ready result handshake; out_sum is signed ACC_W-bit
//   ovf                 saturation seen in the reported group
//   busy                group in progress or result pending
module booth_prod_accum #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 10
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t                  state, state_n;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] add;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [ACC_W-1:0]        out_sum_n;
  logic                    out_valid_n;

  assign prod_ext = ACC_W'($signed(in_product));

`ifdef SAT_ACC_EN
  logic                    sticky, sticky_n;
  logic                    ovf_n;
  logic                    sat_now;
  logic signed [ACC_W:0]   wide;

  // One guard bit; a disagreement between the top two bits means the
  // sum left the ACC_W range, and the guard bit gives its direction.
  assign wide    = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_ext);
  assign sat_now = wide[ACC_W] ^ wide[ACC_W-1];
  assign add     = !sat_now    ? wide[ACC_W-1:0] :
                   wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                 {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign add = acc + prod_ext;
`endif

  // Handshake and status decode straight from the state register.
  assign in_ready = (state != HOLD);
  assign busy     = (state != IDLE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
`ifdef SAT_ACC_EN
      sticky    <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      out_sum   <= out_sum_n;
      out_valid <= out_valid_n;
`ifdef SAT_ACC_EN
      sticky    <= sticky_n;
      ovf       <= ovf_n;
`endif
    end
  end

`ifndef SAT_ACC_EN
  assign ovf = 1'b0;
`endif

  // Next-state and next-datapath logic; clear overrides everything.
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    out_sum_n   = out_sum;
    out_valid_n = out_valid;
`ifdef SAT_ACC_EN
    sticky_n    = sticky;
    ovf_n       = ovf;
`endif
    if (clear) begin
      state_n     = IDLE;
      acc_n       = '0;
      cnt_n       = '0;
      out_valid_n = 1'b0;
`ifdef SAT_ACC_EN
      sticky_n    = 1'b0;
      ovf_n       = 1'b0;
`endif
    end else begin
      case (state)
        IDLE, ACC: begin
          if (in_valid) begin
            if (cnt == LAST_CNT) begin
              out_sum_n   = add;
              out_valid_n = 1'b1;
              acc_n       = '0;
              cnt_n       = '0;
              state_n     = HOLD;
`ifdef SAT_ACC_EN
              ovf_n       = sticky | sat_now;
              sticky_n    = 1'b0;
`endif
            end else begin
              acc_n   = add;
              cnt_n   = cnt + CNT_W'(1);
              state_n = ACC;
`ifdef SAT_ACC_EN
              sticky_n = sticky | sat_now;
`endif
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_n = 1'b0;
            state_n     = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
